// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
// Module   : rob_param
// Purpose  : Depth-configurable reorder buffer with in-order retirement,
//            CDB capture, flush and same-cycle forwarded operand lookup.
// Revision : 1.0
// ============================================================================
module rob_param #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_value,
  input  logic              flush,
  input  logic [TAG_W-1:0]  q_tag1,
  input  logic [TAG_W-1:0]  q_tag2,
  output logic              q_ready1,
  output logic              q_ready2,
  output logic [DATA_W-1:0] q_value1,
  output logic [DATA_W-1:0] q_value2,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0]   c_depth = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] c_one   = TAG_W'(1);

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_done;
  logic [REG_W-1:0]  r_rd    [DEPTH];
  logic [DATA_W-1:0] r_value [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic w_alloc_fire;
  logic w_commit_fire;
  logic w_cdb_hit;
  logic w_fwd1;
  logic w_fwd2;

  assign alloc_ready   = (r_count < c_depth);
  assign alloc_tag     = r_tail;
  assign count         = r_count;
  assign commit_valid  = (r_count != '0) && r_done[r_head] && !flush;
  assign commit_tag    = r_head;
  assign commit_rd     = r_rd[r_head];
  assign commit_value  = r_value[r_head];

  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = commit_valid && commit_ready;
  assign w_cdb_hit     = cdb_valid && r_busy[cdb_tag];

  // A live CDB broadcast is visible to lookups before it lands in storage.
  assign w_fwd1 = cdb_valid && (cdb_tag == q_tag1);
  assign w_fwd2 = cdb_valid && (cdb_tag == q_tag2);

  always_comb begin
    q_ready1 = r_busy[q_tag1] && (r_done[q_tag1] || w_fwd1);
    q_ready2 = r_busy[q_tag2] && (r_done[q_tag2] || w_fwd2);
    q_value1 = '0;
    q_value2 = '0;
    if (q_ready1) q_value1 = w_fwd1 ? cdb_value : r_value[q_tag1];
    if (q_ready2) q_value2 = w_fwd2 ? cdb_value : r_value[q_tag2];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
    end else if (flush) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_cdb_hit) begin
        r_done[cdb_tag]  <= 1'b1;
        r_value[cdb_tag] <= cdb_value;
      end
      // Retirement clears after the CDB write so a late hit on head cannot revive it.
      if (w_commit_fire) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + c_one;
      end
      if (w_alloc_fire) begin
        r_busy[r_tail]  <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_rd[r_tail]    <= alloc_rd;
        r_value[r_tail] <= '0;
        r_tail          <= r_tail + c_one;
      end
      r_count <= r_count + {{TAG_W{1'b0}}, w_alloc_fire}
                         - {{TAG_W{1'b0}}, w_commit_fire};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_param
// Purpose  : Queue-based reference model and directed + random stimulus for rob_param.
// Revision : 1.0
// ============================================================================
module tb_rob_param;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TAG_W  = 3;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              commit_valid;
  logic              commit_ready;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic              flush;
  logic [TAG_W-1:0]  q_tag1;
  logic [TAG_W-1:0]  q_tag2;
  logic              q_ready1;
  logic              q_ready2;
  logic [DATA_W-1:0] q_value1;
  logic [DATA_W-1:0] q_value2;
  logic [TAG_W:0]    count;

  always #5 CLK = ~CLK;

  rob_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush),
    .q_tag1(q_tag1), .q_tag2(q_tag2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .count(count)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: occupied entries in program order; entry i owns tag (m_head+i) mod DEPTH.
  logic [REG_W-1:0]  m_rd   [$];
  logic [DATA_W-1:0] m_val  [$];
  bit                m_done [$];
  int                m_head = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos(input logic [TAG_W-1:0] t);
    return (int'(t) - m_head + DEPTH) % DEPTH;
  endfunction

  task automatic exp_q(input logic [TAG_W-1:0] t, output logic r, output logic [DATA_W-1:0] v);
    int p;
    p = pos(t);
    r = 1'b0;
    v = '0;
    if (p < m_rd.size()) begin
      if (cdb_valid && cdb_tag == t) begin
        r = 1'b1;
        v = cdb_value;
      end else if (m_done[p]) begin
        r = 1'b1;
        v = m_val[p];
      end
    end
  endtask

  always @(negedge CLK) begin
    int n;
    logic ecv, er;
    logic [DATA_W-1:0] ev;
    if (chk_en) begin
      n = m_rd.size();
      chk("alloc_ready", 64'(alloc_ready), 64'(n < DEPTH));
      chk("alloc_tag", 64'(alloc_tag), 64'((m_head + n) % DEPTH));
      chk("count", 64'(count), 64'(n));
      ecv = (n > 0) && m_done[0] && !flush;
      chk("commit_valid", 64'(commit_valid), 64'(ecv));
      chk("commit_tag", 64'(commit_tag), 64'(m_head));
      if (ecv) begin
        chk("commit_rd", 64'(commit_rd), 64'(m_rd[0]));
        chk("commit_value", 64'(commit_value), 64'(m_val[0]));
      end
      exp_q(q_tag1, er, ev);
      chk("q_ready1", 64'(q_ready1), 64'(er));
      chk("q_value1", 64'(q_value1), 64'(ev));
      exp_q(q_tag2, er, ev);
      chk("q_ready2", 64'(q_ready2), 64'(er));
      chk("q_value2", 64'(q_value2), 64'(ev));
    end
  end

  always @(posedge CLK) begin
    int n, p;
    bit af, cf;
    if (!RST_N || flush) begin
      m_rd.delete();
      m_val.delete();
      m_done.delete();
      m_head = 0;
    end else begin
      n  = m_rd.size();
      af = alloc_valid && (n < DEPTH);
      cf = (n > 0) && m_done[0] && commit_ready;
      if (cdb_valid) begin
        p = pos(cdb_tag);
        if (p < n) begin
          m_done[p] = 1'b1;
          m_val[p]  = cdb_value;
        end
      end
      if (cf) begin
        void'(m_rd.pop_front());
        void'(m_val.pop_front());
        void'(m_done.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (af) begin
        m_rd.push_back(alloc_rd);
        m_val.push_back('0);
        m_done.push_back(1'b0);
      end
    end
  end

  task automatic idle();
    RST_N = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    commit_ready = 1'b0; flush = 1'b0; q_tag1 = '0; q_tag2 = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_tag", 64'(commit_tag), 64'd0);
    chk("rst_commit_rd", 64'(commit_rd), 64'd0);
    chk("rst_commit_value", 64'(commit_value), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_q_ready1", 64'(q_ready1), 64'd0);
    chk("rst_q_value1", 64'(q_value1), 64'd0);

    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_rd = REG_W'(i + 1);
      #1;
      chk("seq_alloc_tag", 64'(alloc_tag), 64'(i));
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    chk("seq_count3", 64'(count), 64'd3);
    chk("seq_no_commit", 64'(commit_valid), 64'd0);

    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'hAA;
    tick();
    cdb_tag = 3'd0; cdb_value = 32'h55; q_tag1 = 3'd0;
    #1;
    chk("ooo_no_commit", 64'(commit_valid), 64'd0);
    chk("fwd_ready_t0", 64'(q_ready1), 64'd1);
    chk("fwd_value_t0", 64'(q_value1), 64'h55);
    tick();
    cdb_valid = 1'b0; commit_ready = 1'b1;
    #1;
    chk("c0_valid", 64'(commit_valid), 64'd1);
    chk("c0_rd", 64'(commit_rd), 64'd1);
    chk("c0_value", 64'(commit_value), 64'h55);
    tick();
    chk("c1_rd", 64'(commit_rd), 64'd2);
    chk("c1_value", 64'(commit_value), 64'hAA);
    chk("c1_tag", 64'(commit_tag), 64'd1);
    tick();
    commit_ready = 1'b0;
    #1;
    chk("t2_pending", 64'(commit_valid), 64'd0);
    chk("t2_count", 64'(count), 64'd1);

    q_tag1 = 3'd2; cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'h77;
    #1;
    chk("fwd_ready_t2", 64'(q_ready1), 64'd1);
    chk("fwd_value_t2", 64'(q_value1), 64'h77);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("store_value_t2", 64'(q_value1), 64'h77);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", 64'(commit_valid), 64'd1);
      chk("hold_rd", 64'(commit_rd), 64'd3);
      chk("hold_value", 64'(commit_value), 64'h77);
      tick();
      #1;
    end
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    #1;
    chk("hold_retired", 64'(count), 64'd0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1'b1;
      alloc_rd = REG_W'(i + 8);
      tick();
    end
    #1;
    chk("full_not_ready", 64'(alloc_ready), 64'd0);
    chk("full_count", 64'(count), 64'd8);
    tick();
    chk("full_held_count", 64'(count), 64'd8);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'h1234;
    tick();
    cdb_valid = 1'b0; commit_ready = 1'b1;
    #1;
    chk("full_commit_valid", 64'(commit_valid), 64'd1);
    chk("full_no_bypass", 64'(alloc_ready), 64'd0);
    tick();
    commit_ready = 1'b0;
    #1;
    chk("wrap_ready", 64'(alloc_ready), 64'd1);
    chk("wrap_tag", 64'(alloc_tag), 64'd0);
    chk("wrap_count", 64'(count), 64'd7);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("wrap_refill", 64'(count), 64'd8);

    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'hBEEF;
    tick();
    flush = 1'b1; alloc_valid = 1'b1; cdb_tag = 3'd2; commit_ready = 1'b1;
    #1;
    chk("flush_gates_commit", 64'(commit_valid), 64'd0);
    tick();
    idle();
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_tag", 64'(alloc_tag), 64'd0);
    chk("flush_commit", 64'(commit_valid), 64'd0);

    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick(); tick();
    alloc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'hCAFE;
    tick();
    cdb_valid = 1'b0; RST_N = 1'b0; commit_ready = 1'b1; alloc_valid = 1'b1;
    tick();
    idle();
    #1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_tag", 64'(alloc_tag), 64'd0);
    chk("mrst_commit", 64'(commit_valid), 64'd0);
    chk("mrst_rd_cleared", 64'(commit_rd), 64'd0);

    for (int c = 0; c < 4000; c++) begin
      alloc_valid  = ($urandom % 10) < 6;
      alloc_rd     = REG_W'($urandom);
      cdb_valid    = ($urandom % 4) != 0;
      cdb_tag      = TAG_W'($urandom);
      cdb_value    = $urandom;
      commit_ready = ($urandom % 3) != 0;
      flush        = ($urandom % 100) == 0;
      RST_N        = ($urandom % 250) != 0;
      q_tag1       = TAG_W'($urandom);
      q_tag2       = TAG_W'($urandom);
      tick();
    end
    idle();
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the Tomasulo machine. It allocates one tag per issued instruction in program order and captures results broadcast on the common data bus (CDB). It retires completed entries strictly in order to the register file, and answers operand tag lookups from the reservation stations with same-cycle CDB forwarding. It replaces the fixed 3-bit-tag result tracking with a depth-configurable circular buffer that also supports flush.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- DATA_W, 32, result width
- REG_W, 5, architectural destination register index width
- TAG_W, $clog2(DEPTH), tag width (derived, not overridden)

- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  synchronous active-low reset
- alloc_valid  in  1  issue stage requests a new entry
- alloc_rd  in  REG_W  destination register of issuing instruction
- alloc_ready  out  1  buffer not full
- alloc_tag  out  TAG_W  tag assigned on this cycle's allocation (= tail pointer)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  producing entry tag
- cdb_value  in  DATA_W  result
- commit_valid  out  1  head entry completed and retirable
- commit_ready  in  1  register file accepts retirement
- commit_tag  out  TAG_W  head pointer
- commit_rd  out  REG_W  head entry destination
- commit_value  out  DATA_W  head entry result
- flush  in  1  discard all entries
- q_tag1, q_tag2  in  TAG_W  operand lookup tags
- q_ready1, q_ready2  out  1  looked-up entry has its result available
- q_value1, q_value2  out  DATA_W  looked-up result
- count  out  TAG_W+1  occupied entries

## Operation
- Per-entry state: busy, done, rd, value. head, tail and count are registers.
- Allocate:
  - Fires when alloc_valid && alloc_ready, where alloc_ready = (count < DEPTH).
  - Writes entry[tail] = {busy=1, done=0, rd=alloc_rd, value=0}; tail wraps DEPTH-1 → 0.
  - A full buffer does not accept an allocation in the same cycle as a commit; there is no commit-to-alloc bypass.
- Writeback:
  - Fires when cdb_valid and entry[cdb_tag].busy.
  - Sets done=1 and stores cdb_value.
  - A CDB hit on a non-busy entry is ignored.
  - A second CDB hit to an already-done entry overwrites the value; this is illegal upstream but defined here.
- Commit:
  - commit_valid = (count>0) && entry[head].done && !flush.
  - commit_rd, commit_value and commit_tag are driven combinationally from entry[head].
  - Handshake: the entry retires when commit_valid && commit_ready. Retiring clears busy/done and advances head with wrap.
  - commit_valid is not withdrawn until accepted.
- Count: next = count + alloc_fire − commit_fire, so a simultaneous alloc and commit leaves count unchanged.
- Lookup (combinational):
  - q_readyN = busy[q_tagN] && (done[q_tagN] || (cdb_valid && cdb_tag==q_tagN)).
  - q_valueN = CDB value on a live CDB match, otherwise the stored value. Outputs are 0 when q_readyN=0.
- Flush: at the next edge, clears all busy/done, head=tail=count=0. Flush has priority over alloc, CDB and commit in the same cycle.
- Reset (RST_N=0 at edge): same as flush, and additionally clears rd/value storage. Reset and flush are both honoured mid-operation without draining.

## Timing
- Output values after reset: alloc_ready=1, alloc_tag=0, commit_valid=0, commit_tag=0, commit_rd=0, commit_value=0, count=0; q_ready1/2=0, q_value1/2=0.
- Allocation in cycle n: the entry is visible to lookup and CDB from cycle n+1.
- CDB in cycle n: lookup sees the result in cycle n via forwarding. If the entry is at head, commit_valid rises in cycle n+1.
- Sustained throughput: 1 alloc + 1 CDB + 1 commit per cycle.
- Full: count=DEPTH, alloc_ready=0. A request while full is held off with no state change.
- Empty: count=0, commit_valid=0.
- Pointer wrap is exact modulo DEPTH; count never exceeds DEPTH.

## Test plan
- Reset, then allocate rd=1,2,3 (DEPTH=8) → alloc_tag 0,1,2 on successive cycles, count=3, commit_valid=0.
- CDB tag1=0xAA, then tag0=0x55 → no commit until tag0 done. Then two commits in order: (rd=1, 0x55) then (rd=2, 0xAA); tag2 stays pending.
- Lookup q_tag1=2 in the same cycle as CDB tag2=0x77 → q_ready1=1, q_value1=0x77 that cycle. Afterwards the value comes from storage.
- Fill 8 entries → alloc_ready=0; a 9th alloc_valid is ignored. Commit the head while alloc_valid is held → alloc accepted the next cycle with alloc_tag=0 (wrap).
- Hold commit_ready=0 with head done for 3 cycles → commit_valid and commit payload stable; retirement occurs the cycle commit_ready=1.
- Assert flush together with alloc, CDB and commit, and separately assert RST_N=0 mid-stream → next cycle count=0, alloc_tag=0, commit_valid=0, no retirement observed.
